warp_pc_fetch: RTL and testbench

- Per-warp instruction-fetch PC unit in the IF stage, directly upstream of the ICache/IB and the consumer of the per-warp SIMT divergence unit's redirect/stall outputs.
- Holds the warp PC and raises fetch requests to the warp fetch arbiter.
- Applies SIMT reconvergence, branch and jump redirects, and squashes the single in-flight fetch on any redirect.
- Reports warp completion to the task manager.

---
 rtl/warp_pc_fetch.sv | 135 +++++++++++++
 tb/tb_warp_pc_fetch.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/warp_pc_fetch.sv
// Per-warp fetch PC unit: holds the warp PC, requests fetches, applies SIMT/branch/jump redirects.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module warp_pc_fetch #(
    parameter int PC_W     = 10,
    parameter int PC_INC   = 4,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Update_TM_IF,
    input  logic [PC_W-1:0] StartPC_TM_IF,
    input  logic            Exit_ID_IF,
    input  logic            Stall_SIMT_IF,
    input  logic            UpdatePC_Qual1_SIMT_IF,
    input  logic            UpdatePC_Qual2_SIMT_IF,
    input  logic [PC_W-1:0] TA_Warp_SIMT_IF,
    input  logic [PC_W-1:0] BrTarget_EX_IF,
    input  logic            Jump_ID_IF,
    input  logic [PC_W-1:0] JTarget_ID_IF,
    input  logic            Full_IB_IF,
    input  logic            Grant_Arb_IF,
    output logic            Req_IF_Arb,
    output logic            FetchValid_IF_IC,
    output logic [PC_W-1:0] FetchPC_IF_IC,
    output logic [PC_W-1:0] PCplus4_IF_IB,
    output logic            Squash_IF_IB,
    output logic            Done_IF_TM
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]     FetchCnt_IF_PERF,
    output logic [15:0]     SquashCnt_IF_PERF
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [PC_W-1:0] PC_STEP  = PC_W'(PC_INC);
    localparam logic [PC_W-1:0] PC_RESET = PC_W'(RESET_PC);

    state_t          r_state;
    state_t          w_stateNext;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pcNext;
    logic [PC_W-1:0] w_pcInc;
    logic            r_inFlight;
    logic            w_redirect;
    logic            w_req;
    logic            w_fire;
    logic            w_squash;

    assign w_redirect = Update_TM_IF | UpdatePC_Qual1_SIMT_IF | UpdatePC_Qual2_SIMT_IF | Jump_ID_IF;
    assign w_req      = (r_state == S_ACTIVE) & ~Stall_SIMT_IF & ~Full_IB_IF & ~w_redirect;
    assign w_fire     = w_req & Grant_Arb_IF;
    assign w_squash   = r_inFlight & w_redirect;
    assign w_pcInc    = r_pc + PC_STEP;

    assign Req_IF_Arb       = w_req;
    assign FetchValid_IF_IC = w_fire;
    assign FetchPC_IF_IC    = r_pc;
    assign PCplus4_IF_IB    = w_pcInc;
    assign Squash_IF_IB     = w_squash;
    assign Done_IF_TM       = (r_state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= PC_RESET;
            r_inFlight <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_pc       <= w_pcNext;
            r_inFlight <= w_fire & ~w_redirect;
        end
    end

    // Exit outranks every redirect for the state, but the PC is still written below.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: begin
                if (Update_TM_IF) w_stateNext = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (Exit_ID_IF)         w_stateNext = S_DONE;
                else if (Update_TM_IF)  w_stateNext = S_ACTIVE;
                else if (Stall_SIMT_IF) w_stateNext = S_WAIT;
            end
            S_WAIT: begin
                if (Exit_ID_IF)                      w_stateNext = S_DONE;
                else if (w_redirect | ~Stall_SIMT_IF) w_stateNext = S_ACTIVE;
            end
            S_DONE: begin
                if (Update_TM_IF) w_stateNext = S_ACTIVE;
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_comb begin
        w_pcNext = r_pc;
        if (Update_TM_IF)                w_pcNext = StartPC_TM_IF;
        else if (UpdatePC_Qual2_SIMT_IF) w_pcNext = TA_Warp_SIMT_IF;
        else if (UpdatePC_Qual1_SIMT_IF) w_pcNext = BrTarget_EX_IF;
        else if (Jump_ID_IF)             w_pcNext = JTarget_ID_IF;
        else if (w_fire)                 w_pcNext = w_pcInc;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_fetchCnt;
    logic [15:0] r_squashCnt;

    // Saturating counters; a relaunch starts a fresh measurement window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetchCnt  <= 16'h0000;
            r_squashCnt <= 16'h0000;
        end else if (Update_TM_IF) begin
            r_fetchCnt  <= 16'h0000;
            r_squashCnt <= 16'h0000;
        end else begin
            if (w_fire && (r_fetchCnt != 16'hFFFF))    r_fetchCnt  <= r_fetchCnt + 16'h0001;
            if (w_squash && (r_squashCnt != 16'hFFFF)) r_squashCnt <= r_squashCnt + 16'h0001;
        end
    end

    assign FetchCnt_IF_PERF  = r_fetchCnt;
    assign SquashCnt_IF_PERF = r_squashCnt;
`endif

endmodule

// File: tb/tb_warp_pc_fetch.sv
// Directed, table-driven bench for warp_pc_fetch: one vector per clock cycle, plus an async-reset sequence.
module tb_warp_pc_fetch;

    localparam int PC_W = 10;

    // Control-bit encodings: {update, exit, stall, qual1, qual2, jump, full, grant}
    localparam logic [7:0] U  = 8'h80;
    localparam logic [7:0] E  = 8'h40;
    localparam logic [7:0] S  = 8'h20;
    localparam logic [7:0] Q1 = 8'h10;
    localparam logic [7:0] Q2 = 8'h08;
    localparam logic [7:0] J  = 8'h04;
    localparam logic [7:0] F  = 8'h02;
    localparam logic [7:0] G  = 8'h01;
    // Expected flag encodings: {req, fetchValid, squash, done}
    localparam logic [3:0] R  = 4'h8;
    localparam logic [3:0] V  = 4'h4;
    localparam logic [3:0] SQ = 4'h2;
    localparam logic [3:0] D  = 4'h1;

    typedef struct {
        logic [7:0]      ctl;
        logic [PC_W-1:0] a;
        logic [PC_W-1:0] b;
        logic [3:0]      eFlags;
        logic [PC_W-1:0] eFpc;
        logic [PC_W-1:0] eP4;
    } vec_t;

    logic            clk;
    logic            rst;
    logic            update;
    logic [PC_W-1:0] startPc;
    logic            exitId;
    logic            stall;
    logic            qual1;
    logic            qual2;
    logic [PC_W-1:0] ta;
    logic [PC_W-1:0] brTarget;
    logic            jump;
    logic [PC_W-1:0] jTarget;
    logic            full;
    logic            grant;
    logic            req;
    logic            fetchValid;
    logic [PC_W-1:0] fetchPc;
    logic [PC_W-1:0] pcPlus4;
    logic            squash;
    logic            done;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]     fetchCnt;
    logic [15:0]     squashCnt;
`endif

    int checks = 0;
    int errors = 0;
    vec_t vecs[34];

    warp_pc_fetch #(.PC_W(PC_W), .PC_INC(4), .RESET_PC(0)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .Update_TM_IF           (update),
        .StartPC_TM_IF          (startPc),
        .Exit_ID_IF             (exitId),
        .Stall_SIMT_IF          (stall),
        .UpdatePC_Qual1_SIMT_IF (qual1),
        .UpdatePC_Qual2_SIMT_IF (qual2),
        .TA_Warp_SIMT_IF        (ta),
        .BrTarget_EX_IF         (brTarget),
        .Jump_ID_IF             (jump),
        .JTarget_ID_IF          (jTarget),
        .Full_IB_IF             (full),
        .Grant_Arb_IF           (grant),
        .Req_IF_Arb             (req),
        .FetchValid_IF_IC       (fetchValid),
        .FetchPC_IF_IC          (fetchPc),
        .PCplus4_IF_IB          (pcPlus4),
        .Squash_IF_IB           (squash),
        .Done_IF_TM             (done)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCnt_IF_PERF       (fetchCnt),
        .SquashCnt_IF_PERF      (squashCnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [7:0] ctl, input logic [PC_W-1:0] a, input logic [PC_W-1:0] b);
        update   = ctl[7];
        exitId   = ctl[6];
        stall    = ctl[5];
        qual1    = ctl[4];
        qual2    = ctl[3];
        jump     = ctl[2];
        full     = ctl[1];
        grant    = ctl[0];
        startPc  = a;
        ta       = a;
        brTarget = b;
        jTarget  = b;
    endtask

    task automatic checkOutput(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (step %0d): got %0d, required %0d", name, idx, act, exp);
        end
    endtask

    task automatic checkAll(input int idx, input logic [3:0] eFlags, input logic [PC_W-1:0] eFpc,
                            input logic [PC_W-1:0] eP4);
        checkOutput("Req",        idx, 32'(req),        32'(eFlags[3]));
        checkOutput("FetchValid", idx, 32'(fetchValid), 32'(eFlags[2]));
        checkOutput("Squash",     idx, 32'(squash),     32'(eFlags[1]));
        checkOutput("Done",       idx, 32'(done),       32'(eFlags[0]));
        checkOutput("FetchPC",    idx, 32'(fetchPc),    32'(eFpc));
        checkOutput("PCplus4",    idx, 32'(pcPlus4),    32'(eP4));
    endtask

    initial begin
        // Launch at 0 and fetch 0,4,8,12
        vecs[0]  = '{G,      10'd0,   10'd0,    4'h0,   10'd0,    10'd4};
        vecs[1]  = '{U|G,    10'd0,   10'd0,    4'h0,   10'd0,    10'd4};
        vecs[2]  = '{G,      10'd0,   10'd0,    R|V,    10'd0,    10'd4};
        vecs[3]  = '{G,      10'd0,   10'd0,    R|V,    10'd4,    10'd8};
        vecs[4]  = '{G,      10'd0,   10'd0,    R|V,    10'd8,    10'd12};
        vecs[5]  = '{G,      10'd0,   10'd0,    R|V,    10'd12,   10'd16};
        // Relaunch at 4 squashes the fetch of 12; then a 3-cycle stall
        vecs[6]  = '{U|G,    10'd4,   10'd0,    SQ,     10'd16,   10'd20};
        vecs[7]  = '{S|G,    10'd0,   10'd0,    4'h0,   10'd4,    10'd8};
        vecs[8]  = '{S|G,    10'd0,   10'd0,    4'h0,   10'd4,    10'd8};
        vecs[9]  = '{S|G,    10'd0,   10'd0,    4'h0,   10'd4,    10'd8};
        vecs[10] = '{G,      10'd0,   10'd0,    4'h0,   10'd4,    10'd8};
        vecs[11] = '{G,      10'd0,   10'd0,    R|V,    10'd4,    10'd8};
        vecs[12] = '{G,      10'd0,   10'd0,    R|V,    10'd8,    10'd12};
        vecs[13] = '{G,      10'd0,   10'd0,    R|V,    10'd12,   10'd16};
        vecs[14] = '{G,      10'd0,   10'd0,    R|V,    10'd16,   10'd20};
        // Branch redirect to 24 squashes the fetch of 16
        vecs[15] = '{Q1|G,   10'd0,   10'd24,   SQ,     10'd20,   10'd24};
        vecs[16] = '{G,      10'd0,   10'd0,    R|V,    10'd24,   10'd28};
        // IB full, then no grant: PC holds at 28
        vecs[17] = '{F|G,    10'd0,   10'd0,    4'h0,   10'd28,   10'd32};
        vecs[18] = '{8'h00,  10'd0,   10'd0,    R,      10'd28,   10'd32};
        // Qual2 beats Jump; squash only when the previous cycle fired
        vecs[19] = '{Q2|J|G, 10'd16,  10'd40,   4'h0,   10'd28,   10'd32};
        vecs[20] = '{G,      10'd0,   10'd0,    R|V,    10'd16,   10'd20};
        vecs[21] = '{Q2|J|G, 10'd16,  10'd40,   SQ,     10'd20,   10'd24};
        vecs[22] = '{G,      10'd0,   10'd0,    R|V,    10'd16,   10'd20};
        // Jump to 1020, fetch wraps to 0
        vecs[23] = '{J|G,    10'd0,   10'd1020, SQ,     10'd20,   10'd24};
        vecs[24] = '{G,      10'd0,   10'd0,    R|V,    10'd1020, 10'd0};
        vecs[25] = '{G,      10'd0,   10'd0,    R|V,    10'd0,    10'd4};
        // Exit at 32, relaunch at 100, then Exit racing a branch redirect
        vecs[26] = '{J|G,    10'd0,   10'd32,   SQ,     10'd4,    10'd8};
        vecs[27] = '{E,      10'd0,   10'd0,    R,      10'd32,   10'd36};
        vecs[28] = '{G,      10'd0,   10'd0,    D,      10'd32,   10'd36};
        vecs[29] = '{G,      10'd0,   10'd0,    D,      10'd32,   10'd36};
        vecs[30] = '{U|G,    10'd100, 10'd0,    D,      10'd32,   10'd36};
        vecs[31] = '{G,      10'd0,   10'd0,    R|V,    10'd100,  10'd104};
        vecs[32] = '{E|Q1|G, 10'd0,   10'd200,  SQ,     10'd104,  10'd108};
        vecs[33] = '{G,      10'd0,   10'd0,    D,      10'd200,  10'd204};

        rst = 1'b0;
        applyStimulus(8'h00, '0, '0);
        #1 rst = 1'b1;
        #2 checkAll(-1, 4'h0, 10'd0, 10'd4);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 34; i++) begin
            applyStimulus(vecs[i].ctl, vecs[i].a, vecs[i].b);
            #1 checkAll(i, vecs[i].eFlags, vecs[i].eFpc, vecs[i].eP4);
            @(negedge clk);
        end

        // Relaunch at 8, fetch once, stall into WAIT, then reset asynchronously mid-cycle
        applyStimulus(U|G, 10'd8, 10'd0);
        @(negedge clk);
        applyStimulus(G, 10'd0, 10'd0);
        #1 checkAll(100, R|V, 10'd8, 10'd12);
        @(negedge clk);
        applyStimulus(S|G, 10'd0, 10'd0);
        @(negedge clk);
        #1 checkAll(101, 4'h0, 10'd12, 10'd16);
        #2 rst = 1'b1;
        #1 checkAll(102, 4'h0, 10'd0, 10'd4);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(G, 10'd0, 10'd0);
        #1 checkAll(103, 4'h0, 10'd0, 10'd4);
        @(negedge clk);
        #1 checkAll(104, 4'h0, 10'd0, 10'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
